led_select_sequencer: RTL and testbench
=======================================

Name: led_select_sequencer

Overview:
Upstream stage for the 1-to-4 LED demux. Synchronises and debounces the two push-switches. Turns debounced press/release gestures into a 2-bit wrap-around LED select (Sel0/Sel1), so each switch steps the lit LED instead of statically encoding it. Holding both switches toggles an auto-scan mode that advances the select periodically.

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive cycles a synchronised switch must differ from its debounced value before the debounced value flips (10 ms at 25 MHz); legal range is 1 and above
HOLD_LIMIT, 25000000, consecutive cycles both switches must be held to toggle auto mode (1 s); must be greater than DEBOUNCE_LIMIT
AUTO_LIMIT, 12500000, cycles between auto-scan advances (0.5 s); legal range is 2 and above

Ports:
i_Clk  in  1  system clock; all logic on rising edge
i_Rst_L  in  1  synchronous, active-low reset
i_Switch_1  in  1  raw switch, active-high, asynchronous; step up
i_Switch_2  in  1  raw switch, active-high, asynchronous; step down
o_Sel0  out  1  select LSB, to demux i_Sel0
o_Sel1  out  1  select MSB, to demux i_Sel1
o_Sel_Change  out  1  one-cycle pulse; high in the first cycle o_Sel1:o_Sel0 holds a new value
o_Auto  out  1  auto-scan mode active

Behaviour:
- Reset (i_Rst_L low at an edge):
  - Sel = 0, o_Sel_Change = 0, o_Auto = 0.
  - Debounced switches = 0; all counters = 0; FSM = IDLE.
  - Reset mid-gesture discards the gesture. A switch still held after reset re-debounces from 0 and is treated as a fresh press.
- Synchronisation: each raw switch passes through 2 flops.
- Debounce, per switch, independent:
  - Counter increments while the synchronised value differs from the debounced value. It clears to 0 when they match.
  - When the counter reaches DEBOUNCE_LIMIT-1 while still differing, the debounced value flips at that edge and the counter clears.
  - Net latency from a stable raw change to the debounced change: 2 + DEBOUNCE_LIMIT cycles.
- Sel is a 2-bit register {o_Sel1,o_Sel0}.
  - Increment wraps 3 to 0; decrement wraps 0 to 3.
- FSM (operates on debounced D1/D2):
  - IDLE:
    - D1 & !D2 -> S1_HELD.
    - !D1 & D2 -> S2_HELD.
    - D1 & D2 -> BOTH_HELD (hold counter cleared).
  - S1_HELD:
    - D2 rises -> BOTH_HELD.
    - Else D1 falls -> Sel+1, go to IDLE.
  - S2_HELD:
    - D1 rises -> BOTH_HELD.
    - Else D2 falls -> Sel-1, go to IDLE.
  - BOTH_HELD (never steps Sel):
    - Hold counter increments each cycle both are high.
    - On the cycle it reaches HOLD_LIMIT-1, o_Auto toggles once and the state moves to WAIT_RELEASE.
    - If either switch drops first -> WAIT_RELEASE with no toggle.
  - WAIT_RELEASE: stays until D1 = D2 = 0, then IDLE. A single remaining switch never steps Sel.
- Manual step timing: Sel updates at the edge after the debounced release is seen. o_Sel_Change is high for exactly the following cycle.
- Auto scan:
  - While o_Auto = 1, the auto counter counts 0..AUTO_LIMIT-1. At terminal count it does Sel+1 and wraps to 0.
  - The counter clears when o_Auto turns on, and on any manual step.
  - Manual step and auto terminal count on the same cycle: only the manual step applies (single change, single o_Sel_Change pulse); the auto counter restarts.
  - o_Auto turning off freezes Sel at its current value.
- o_Sel_Change is never high for 2 consecutive cycles unless two separate updates occur. It is 0 whenever Sel is unchanged.

Test Plan:
(Test parameters: DEBOUNCE_LIMIT=4, HOLD_LIMIT=20, AUTO_LIMIT=10.)
1. After reset, press then release i_Switch_1 (held 10 cycles) -> Sel 0→1. o_Sel_Change is high for one cycle, exactly 2+4+1 cycles after the raw release. Repeat 4 times -> sequence 1,2,3,0.
2. From Sel=0, press/release i_Switch_2 -> Sel=3. A 2-cycle glitch on i_Switch_2 (shorter than DEBOUNCE_LIMIT) -> no change, no pulse.
3. Hold both switches 30 cycles, then release -> o_Auto=1, Sel unchanged. Sel then advances every 10 cycles (0,1,2,3,0). Hold both again for 30 cycles -> o_Auto=0 and Sel freezes.
4. Hold both 10 cycles (less than HOLD_LIMIT), then release i_Switch_2 first, then i_Switch_1 -> no Sel change, o_Auto unchanged.
5. In auto mode, time a manual i_Switch_1 step to coincide with the auto terminal count -> a single +1 and one o_Sel_Change pulse. The next auto step comes 10 cycles later.
6. Assert i_Rst_L=0 while i_Switch_1 is held at Sel=2 in auto mode -> Sel=0, o_Auto=0, no pulse. Releasing after reset produces +1 only once re-debounce completes.

Source files
------------

// File: rtl/led_select_sequencer.sv
// Switch front end for the 1-to-4 LED demux: synchronises and debounces two push-switches
// and turns press/release gestures (plus a hold-both auto-scan toggle) into a 2-bit select.
module led_select_sequencer #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int HOLD_LIMIT     = 25000000,
    parameter int AUTO_LIMIT     = 12500000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Sel0,
    output logic o_Sel1,
    output logic o_Sel_Change,
    output logic o_Auto
);

    localparam int DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);
    localparam int AUTO_W = $clog2(AUTO_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        S1_HELD,
        S2_HELD,
        BOTH_HELD,
        WAIT_RELEASE
    } state_t;

    // Select arithmetic wraps naturally in two bits: 3+1 -> 0, 0-1 -> 3.
    function automatic logic [1:0] sel_step(input logic [1:0] sel, input logic up);
        return up ? sel + 2'd1 : sel - 2'd1;
    endfunction

    logic [1:0]        sw_p0;
    logic [1:0]        sw_p1;
    logic [1:0]        sw_db;
    logic [DB_W-1:0]   db_cnt [2];
    state_t            state;
    logic [1:0]        sel;
    logic [HOLD_W-1:0] hold_cnt;
    logic [AUTO_W-1:0] auto_cnt;
    logic              step_up;
    logic              step_dn;
    logic              auto_tc;

    // Stage p0/p1: two-flop synchronisers; bit 0 is switch 1, bit 1 is switch 2.
    always_ff @(posedge i_Clk) begin
        sw_p0 <= {i_Switch_2, i_Switch_1};
        sw_p1 <= sw_p0;
    end

    // Debounce: flip only after DEBOUNCE_LIMIT consecutive cycles of disagreement.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sw_db     <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sw_p1[i] != sw_db[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_LIMIT - 1)) begin
                        sw_db[i]  <= sw_p1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A single-switch gesture completes when its switch is released with the other still up.
    assign step_up = (state == S1_HELD) && !sw_db[1] && !sw_db[0];
    assign step_dn = (state == S2_HELD) && !sw_db[0] && !sw_db[1];
    assign auto_tc = o_Auto && (auto_cnt == AUTO_W'(AUTO_LIMIT - 1));

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            sel          <= 2'd0;
            o_Sel_Change <= 1'b0;
            o_Auto       <= 1'b0;
            hold_cnt     <= '0;
            auto_cnt     <= '0;
        end else begin
            // A manual step wins over a coincident auto terminal count.
            o_Sel_Change <= 1'b0;
            if (step_up || step_dn) begin
                sel          <= sel_step(sel, step_up);
                o_Sel_Change <= 1'b1;
            end else if (auto_tc) begin
                sel          <= sel_step(sel, 1'b1);
                o_Sel_Change <= 1'b1;
            end

            // Held at zero while auto is off, so it starts from zero when auto turns on.
            if (!o_Auto || step_up || step_dn || auto_tc) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + AUTO_W'(1);
            end

            case (state)
                IDLE: begin
                    if (sw_db[0] && sw_db[1]) begin
                        state    <= BOTH_HELD;
                        hold_cnt <= '0;
                    end else if (sw_db[0]) begin
                        state <= S1_HELD;
                    end else if (sw_db[1]) begin
                        state <= S2_HELD;
                    end
                end
                S1_HELD: begin
                    if (sw_db[1]) begin
                        state    <= BOTH_HELD;
                        hold_cnt <= '0;
                    end else if (!sw_db[0]) begin
                        state <= IDLE;
                    end
                end
                S2_HELD: begin
                    if (sw_db[0]) begin
                        state    <= BOTH_HELD;
                        hold_cnt <= '0;
                    end else if (!sw_db[1]) begin
                        state <= IDLE;
                    end
                end
                BOTH_HELD: begin
                    if (sw_db[0] && sw_db[1]) begin
                        if (hold_cnt == HOLD_W'(HOLD_LIMIT - 1)) begin
                            o_Auto <= !o_Auto;
                            state  <= WAIT_RELEASE;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end else begin
                        state <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!sw_db[0] && !sw_db[1]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_Sel0 = sel[0];
    assign o_Sel1 = sel[1];

endmodule

// File: tb/tb_led_select_sequencer.sv
// Scoreboard bench for led_select_sequencer: each gesture queues the select value it should
// produce and when the o_Sel_Change pulse should appear; a monitor pops on every pulse.
module tb_led_select_sequencer;

    localparam int DL = 4;
    localparam int HL = 20;
    localparam int AL = 10;

    localparam int M_ANY = 0;
    localparam int M_ABS = 1;
    localparam int M_GAP = 2;

    typedef struct {
        int sel;
        int mode;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic sw1 = 1'b0;
    logic sw2 = 1'b0;
    logic sel0;
    logic sel1;
    logic chg;
    logic auto_o;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pulse = 0;
    int exp_sel = 0;
    int prev_sel = 0;
    int mon_cur;
    logic mon_rst;
    exp_t mon_e;

    led_select_sequencer #(
        .DEBOUNCE_LIMIT(DL),
        .HOLD_LIMIT(HL),
        .AUTO_LIMIT(AL)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_l),
        .i_Switch_1(sw1),
        .i_Switch_2(sw2),
        .o_Sel0(sel0),
        .o_Sel1(sel1),
        .o_Sel_Change(chg),
        .o_Auto(auto_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sel_now();
        return int'({sel1, sel0});
    endfunction

    task automatic push(input int s, input int m, input int t);
        sb.push_back('{s, m, t});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Press, hold, release one switch; the step lands 2 + DL + 1 cycles after the release.
    task automatic manual_step(input bit up, input int hold);
        if (up) sw1 = 1'b1; else sw2 = 1'b1;
        tick(hold);
        if (up) sw1 = 1'b0; else sw2 = 1'b0;
        exp_sel = (exp_sel + (up ? 1 : 3)) % 4;
        push(exp_sel, M_ABS, cyc + 2 + DL + 1);
        wait_drain(30);
        tick(5);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        mon_rst = !rst_l;
        #1;
        cyc = cyc + 1;
        mon_cur = sel_now();
        if (mon_rst) begin
            if (mon_cur != prev_sel || chg) chk("reset_no_pulse", int'(chg), 0);
        end else if (chg) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sel_value", mon_cur, mon_e.sel);
                if (mon_e.mode == M_ABS) chk("pulse_cycle", cyc, mon_e.t);
                else if (mon_e.mode == M_GAP) chk("pulse_gap", cyc - last_pulse, mon_e.t);
            end
            chk("pulse_with_change", int'(mon_cur != prev_sel), 1);
            last_pulse = cyc;
        end else if (mon_cur != prev_sel) begin
            chk("change_without_pulse", mon_cur, prev_sel);
        end
        prev_sel = mon_cur;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst_l = 1'b0;
        tick(3);
        chk("rst_sel", sel_now(), 0);
        chk("rst_chg", int'(chg), 0);
        chk("rst_auto", int'(auto_o), 0);
        rst_l = 1'b1;
        tick(2);

        // Step up four times: 1, 2, 3, 0.
        for (int i = 0; i < 4; i++) manual_step(1'b1, 10);
        chk("t1_wrap_sel", sel_now(), 0);

        // Step down wraps 0 -> 3; a short glitch is ignored.
        manual_step(1'b0, 10);
        sw2 = 1'b1;
        tick(2);
        sw2 = 1'b0;
        tick(20);
        chk("t2_glitch_sel", sel_now(), 3);
        manual_step(1'b1, 10);

        // Hold both: auto on, select untouched by the gesture, then scans every AL cycles.
        sw1 = 1'b1;
        sw2 = 1'b1;
        tick(30);
        chk("t3_auto_on", int'(auto_o), 1);
        chk("t3_sel_unchanged", sel_now(), exp_sel);
        sw1 = 1'b0;
        sw2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_sel = (exp_sel + 1) % 4;
            push(exp_sel, (i == 0) ? M_ANY : M_GAP, AL);
        end
        wait_drain(80);
        // Hold both again right after a scan step: two more steps, then auto off and freeze.
        sw1 = 1'b1;
        sw2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_sel = (exp_sel + 1) % 4;
            push(exp_sel, M_GAP, AL);
        end
        tick(30);
        chk("t3_auto_off", int'(auto_o), 0);
        sw1 = 1'b0;
        sw2 = 1'b0;
        wait_drain(10);
        tick(40);
        chk("t3_frozen_sel", sel_now(), exp_sel);
        chk("t3_still_off", int'(auto_o), 0);

        // Short hold of both, staggered release: no step, no toggle.
        sw1 = 1'b1;
        sw2 = 1'b1;
        tick(10);
        sw2 = 1'b0;
        tick(5);
        sw1 = 1'b0;
        tick(20);
        chk("t4_sel", sel_now(), exp_sel);
        chk("t4_auto", int'(auto_o), 0);

        // Auto on, then a manual step landing on an auto terminal count.
        sw1 = 1'b1;
        sw2 = 1'b1;
        tick(30);
        chk("t5_auto_on", int'(auto_o), 1);
        sw1 = 1'b0;
        sw2 = 1'b0;
        exp_sel = (exp_sel + 1) % 4;
        push(exp_sel, M_ANY, 0);
        wait_drain(80);
        p = cyc;
        sw1 = 1'b1;
        exp_sel = (exp_sel + 1) % 4;
        push(exp_sel, M_GAP, AL);
        tick(13);
        sw1 = 1'b0;
        exp_sel = (exp_sel + 1) % 4;
        push(exp_sel, M_ABS, p + 20);
        exp_sel = (exp_sel + 1) % 4;
        push(exp_sel, M_GAP, AL);
        wait_drain(60);
        chk("t5_sel", sel_now(), 2);

        // Reset while switch 1 is held in auto mode; the held switch becomes a fresh press.
        sw1 = 1'b1;
        tick(8);
        rst_l = 1'b0;
        exp_sel = 0;
        tick(3);
        chk("t6_rst_sel", sel_now(), 0);
        chk("t6_rst_chg", int'(chg), 0);
        chk("t6_rst_auto", int'(auto_o), 0);
        rst_l = 1'b1;
        tick(10);
        chk("t6_held_sel", sel_now(), 0);
        sw1 = 1'b0;
        exp_sel = 1;
        push(exp_sel, M_ABS, cyc + 2 + DL + 1);
        wait_drain(30);
        tick(30);
        chk("t6_final_sel", sel_now(), 1);
        chk("t6_final_auto", int'(auto_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
